cv32e40p_ex_wb_queue: RTL and testbench

//  Parametrised EX->WB writeback tracker for the LSU path; generalises the single-entry EX/WB register to DEPTH outstanding transactions.

---
 rtl/cv32e40p_ex_wb_queue.sv | 126 ++++++++++++
 tb/tb_cv32e40p_ex_wb_queue.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_ex_wb_queue.sv
// Purpose : in-order EX->WB writeback tracker for up to DEPTH outstanding LSU ops.
// Latency : LSU response to registered regfile write is 1 cycle.
// Backpressure: ex_ready_o low while full; a response in the same cycle does not free a slot for EX.
//
// Ports
//   clk, rst                  clock and synchronous active-high reset
//   flush_i                   kill every queued writeback (entries stay for response draining)
//   ex_valid_i                EX hands over an LSU op; stored with regfile_we_i/regfile_waddr_i
//   ex_ready_o                queue can accept an op (not full)
//   lsu_rvalid_i              response for the oldest outstanding op, data lsu_rdata_i, error lsu_err_i
//   check_addr_i, hazard_o    ID-stage RAW check against pending queued writes
//   count_o                   occupancy 0..DEPTH
//   spurious_rvalid_o         sticky flag: response arrived with nothing outstanding
//   regfile_*_wb_o            registered regfile write port
module cv32e40p_ex_wb_queue #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       ex_valid_i,
  input  logic                       regfile_we_i,
  input  logic [ADDR_W-1:0]          regfile_waddr_i,
  output logic                       ex_ready_o,
  input  logic                       lsu_rvalid_i,
  input  logic [DATA_W-1:0]          lsu_rdata_i,
  input  logic                       lsu_err_i,
  input  logic [ADDR_W-1:0]          check_addr_i,
  output logic                       hazard_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       spurious_rvalid_o,
  output logic                       regfile_we_wb_o,
  output logic [ADDR_W-1:0]          regfile_waddr_wb_o,
  output logic [DATA_W-1:0]          regfile_wdata_wb_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count_q;
  logic [DEPTH-1:0]  ent_we;
  logic [ADDR_W-1:0] ent_waddr [DEPTH];
  logic              enq;
  logic              deq;
  logic              empty;

  assign empty      = (count_q == '0);
  assign ex_ready_o = (count_q != FULL_CNT);
  assign enq        = ex_valid_i & ex_ready_o;
  assign deq        = lsu_rvalid_i & ~empty;
  assign count_o    = count_q;

  // Pointers, occupancy, write-enable bits and the WB register.
  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr             <= '0;
      wr_ptr             <= '0;
      count_q            <= '0;
      ent_we             <= '0;
      spurious_rvalid_o  <= 1'b0;
      regfile_we_wb_o    <= 1'b0;
      regfile_waddr_wb_o <= '0;
      regfile_wdata_wb_o <= '0;
    end else begin
      regfile_we_wb_o <= 1'b0;
      if (deq) begin
        // A pop in the flush cycle is killed here too, since its we bit is
        // still the pre-flush value.
        regfile_we_wb_o    <= ent_we[rd_ptr] & ~lsu_err_i & ~flush_i;
        regfile_waddr_wb_o <= ent_waddr[rd_ptr];
        regfile_wdata_wb_o <= lsu_rdata_i;
        rd_ptr             <= rd_ptr + 1'b1;
      end

      if (lsu_rvalid_i && empty) begin
        spurious_rvalid_o <= 1'b1;
      end

      // Flush clears the write intent only; entries remain so the
      // outstanding responses still pop in order.
      if (flush_i) begin
        ent_we <= '0;
      end
      if (enq) begin
        ent_we[wr_ptr] <= regfile_we_i & ~flush_i;
        wr_ptr         <= wr_ptr + 1'b1;
      end

      case ({enq, deq})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Address payload needs no reset: it is only meaningful where we is set.
  always_ff @(posedge clk) begin
    if (enq) begin
      ent_waddr[wr_ptr] <= regfile_waddr_i;
    end
  end

  // RAW check over live entries, oldest first. The entry popping this cycle
  // is still live here; the WB register is covered by regfile write-through.
  always_comb begin
    hazard_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count_q) &&
          ent_we[rd_ptr + PW'(i)] &&
          (ent_waddr[rd_ptr + PW'(i)] == check_addr_i)) begin
        hazard_o = 1'b1;
      end
    end
    if (check_addr_i == '0) begin
      hazard_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_cv32e40p_ex_wb_queue.sv
module tb_cv32e40p_ex_wb_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // index 0: DEPTH=2 instance, index 1: DEPTH=4 instance
  logic        rst;
  logic        flush      [2];
  logic        ex_valid   [2];
  logic        we_in      [2];
  logic [5:0]  waddr_in   [2];
  logic        rvalid     [2];
  logic [31:0] rdata      [2];
  logic        err        [2];
  logic [5:0]  check_addr [2];
  logic        ex_ready   [2];
  logic        hazard     [2];
  logic        spur       [2];
  logic        we_wb      [2];
  logic [5:0]  waddr_wb   [2];
  logic [31:0] wdata_wb   [2];
  logic [1:0]  cnt2;
  logic [2:0]  cnt4;

  cv32e40p_ex_wb_queue #(.DEPTH(2), .DATA_W(32), .ADDR_W(6)) dut2 (
    .clk(clk), .rst(rst), .flush_i(flush[0]),
    .ex_valid_i(ex_valid[0]), .regfile_we_i(we_in[0]), .regfile_waddr_i(waddr_in[0]),
    .ex_ready_o(ex_ready[0]),
    .lsu_rvalid_i(rvalid[0]), .lsu_rdata_i(rdata[0]), .lsu_err_i(err[0]),
    .check_addr_i(check_addr[0]), .hazard_o(hazard[0]), .count_o(cnt2),
    .spurious_rvalid_o(spur[0]),
    .regfile_we_wb_o(we_wb[0]), .regfile_waddr_wb_o(waddr_wb[0]), .regfile_wdata_wb_o(wdata_wb[0])
  );

  cv32e40p_ex_wb_queue #(.DEPTH(4), .DATA_W(32), .ADDR_W(6)) dut4 (
    .clk(clk), .rst(rst), .flush_i(flush[1]),
    .ex_valid_i(ex_valid[1]), .regfile_we_i(we_in[1]), .regfile_waddr_i(waddr_in[1]),
    .ex_ready_o(ex_ready[1]),
    .lsu_rvalid_i(rvalid[1]), .lsu_rdata_i(rdata[1]), .lsu_err_i(err[1]),
    .check_addr_i(check_addr[1]), .hazard_o(hazard[1]), .count_o(cnt4),
    .spurious_rvalid_o(spur[1]),
    .regfile_we_wb_o(we_wb[1]), .regfile_waddr_wb_o(waddr_wb[1]), .regfile_wdata_wb_o(wdata_wb[1])
  );

  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] data;
  } wr_t;

  // Behavioural model: list of outstanding ops in a 16-slot ring, plus
  // scoreboards of expected regfile writes in issue order.
  int         m_cnt  [2];
  int         m_head [2];
  bit         m_spur [2];
  bit         m_we   [2][16];
  logic [5:0] m_addr [2][16];
  bit         nxt_we [2];
  wr_t        exp_q0 [$];
  wr_t        exp_q1 [$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model with the currently driven inputs, clock once, then
  // compare every cycle-level output and pop the scoreboard on each write.
  task automatic tick();
    for (int d = 0; d < 2; d++) begin
      int  dep;
      int  tail;
      bit  enq;
      bit  deq;
      wr_t e;
      dep = (d == 0) ? 2 : 4;
      if (rst) begin
        m_cnt[d]  = 0;
        m_head[d] = 0;
        m_spur[d] = 0;
        nxt_we[d] = 0;
        for (int j = 0; j < 16; j++) m_we[d][j] = 0;
        if (d == 0) exp_q0.delete(); else exp_q1.delete();
      end else begin
        enq  = ex_valid[d] && (m_cnt[d] != dep);
        deq  = rvalid[d] && (m_cnt[d] != 0);
        tail = (m_head[d] + m_cnt[d]) % 16;
        nxt_we[d] = 0;
        if (deq) begin
          if (m_we[d][m_head[d]] && !err[d] && !flush[d]) begin
            nxt_we[d] = 1;
            e.addr = m_addr[d][m_head[d]];
            e.data = rdata[d];
            if (d == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
          end
          m_head[d] = (m_head[d] + 1) % 16;
        end
        if (rvalid[d] && m_cnt[d] == 0) m_spur[d] = 1;
        if (flush[d]) for (int j = 0; j < 16; j++) m_we[d][j] = 0;
        if (enq) begin
          m_we[d][tail]   = we_in[d] && !flush[d];
          m_addr[d][tail] = waddr_in[d];
        end
        m_cnt[d] = m_cnt[d] + (enq ? 1 : 0) - (deq ? 1 : 0);
      end
    end

    @(posedge clk);
    #1;

    for (int d = 0; d < 2; d++) begin
      int  dep;
      wr_t e;
      dep = (d == 0) ? 2 : 4;
      chk($sformatf("d%0d we_wb", d), we_wb[d], nxt_we[d]);
      chk($sformatf("d%0d count", d), (d == 0) ? 32'(cnt2) : 32'(cnt4), m_cnt[d]);
      chk($sformatf("d%0d spurious", d), spur[d], m_spur[d]);
      chk($sformatf("d%0d ex_ready", d), ex_ready[d], (m_cnt[d] != dep));
      if (we_wb[d] === 1'b1) begin
        if (d == 0 && exp_q0.size() > 0) begin
          e = exp_q0.pop_front();
          chk("d0 wb waddr order", waddr_wb[0], e.addr);
          chk("d0 wb wdata order", wdata_wb[0], e.data);
        end else if (d == 1 && exp_q1.size() > 0) begin
          e = exp_q1.pop_front();
          chk("d1 wb waddr order", waddr_wb[1], e.addr);
          chk("d1 wb wdata order", wdata_wb[1], e.data);
        end
      end
    end
  endtask

  task automatic enq_op(input int d, input logic we, input logic [5:0] a);
    ex_valid[d] = 1'b1;
    we_in[d]    = we;
    waddr_in[d] = a;
    tick();
    ex_valid[d] = 1'b0;
  endtask

  task automatic resp(input int d, input logic [31:0] data, input logic e);
    rvalid[d] = 1'b1;
    rdata[d]  = data;
    err[d]    = e;
    tick();
    rvalid[d] = 1'b0;
    err[d]    = 1'b0;
  endtask

  task automatic hz(input int d, input logic [5:0] a, input logic exp, input string tag);
    check_addr[d] = a;
    #1;
    chk(tag, hazard[d], exp);
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      flush[d] = 0; ex_valid[d] = 0; we_in[d] = 0; waddr_in[d] = '0;
      rvalid[d] = 0; rdata[d] = '0; err[d] = 0; check_addr[d] = '0;
      m_cnt[d] = 0; m_head[d] = 0; m_spur[d] = 0; nxt_we[d] = 0;
    end
    #2;
    tick();
    tick();
    rst = 1'b0;
    chk("reset d0 waddr_wb", waddr_wb[0], 0);
    chk("reset d0 wdata_wb", wdata_wb[0], 0);
    chk("reset d1 waddr_wb", waddr_wb[1], 0);
    chk("reset d1 wdata_wb", wdata_wb[1], 0);

    // 1: single load, one-cycle writeback
    enq_op(0, 1'b1, 6'd5);
    resp(0, 32'hDEADBEEF, 1'b0);
    chk("t1 we_wb", we_wb[0], 1);
    chk("t1 waddr_wb", waddr_wb[0], 5);
    chk("t1 wdata_wb", wdata_wb[0], 32'hDEADBEEF);
    tick();
    chk("t1 waddr holds", waddr_wb[0], 5);

    // 2: fill with load+store, held op while full is dropped
    enq_op(0, 1'b1, 6'd3);
    enq_op(0, 1'b0, 6'd12);
    chk("t2 full ready", ex_ready[0], 0);
    ex_valid[0] = 1'b1; we_in[0] = 1'b1; waddr_in[0] = 6'd7;
    tick();
    tick();
    ex_valid[0] = 1'b0;
    chk("t2 count full", cnt2, 2);
    hz(0, 6'd7, 1'b0, "t2 x7 not stored");
    hz(0, 6'd3, 1'b1, "t2 x3 pending");
    hz(0, 6'd12, 1'b0, "t2 store no hazard");
    resp(0, 32'h0000_0033, 1'b0);
    chk("t2 load write addr", waddr_wb[0], 3);
    chk("t2 load write data", wdata_wb[0], 32'h33);
    resp(0, 32'h0000_0044, 1'b0);
    chk("t2 store silent", we_wb[0], 0);
    chk("t2 drained", cnt2, 0);

    // 3: hazard detection
    enq_op(0, 1'b1, 6'd4);
    hz(0, 6'd4, 1'b1, "t3 hazard x4");
    enq_op(0, 1'b1, 6'd0);
    hz(0, 6'd0, 1'b0, "t3 x0 never hazard");
    hz(0, 6'd4, 1'b1, "t3 x4 still");
    rvalid[0] = 1'b1; rdata[0] = 32'h4444_0000;
    hz(0, 6'd4, 1'b1, "t3 popping entry counts");
    tick();
    hz(0, 6'd4, 1'b0, "t3 after pop");
    rdata[0] = 32'h0000_0001;
    tick();
    rvalid[0] = 1'b0;
    tick();

    // 4: flush kills queued writes, entries still drain
    enq_op(0, 1'b1, 6'd8);
    enq_op(0, 1'b1, 6'd9);
    hz(0, 6'd9, 1'b1, "t4 pre-flush hazard");
    flush[0] = 1'b1;
    tick();
    flush[0] = 1'b0;
    hz(0, 6'd9, 1'b0, "t4 x9 flushed");
    hz(0, 6'd8, 1'b0, "t4 x8 flushed");
    chk("t4 count kept", cnt2, 2);
    resp(0, 32'h8888_8888, 1'b0);
    resp(0, 32'h9999_9999, 1'b0);
    chk("t4 count drained", cnt2, 0);
    flush[0] = 1'b1; ex_valid[0] = 1'b1; we_in[0] = 1'b1; waddr_in[0] = 6'd10;
    tick();
    flush[0] = 1'b0; ex_valid[0] = 1'b0;
    hz(0, 6'd10, 1'b0, "t4 enq in flush killed");
    resp(0, 32'hAAAA_AAAA, 1'b0);
    enq_op(0, 1'b1, 6'd13);
    rvalid[0] = 1'b1; rdata[0] = 32'hDDDD_DDDD; flush[0] = 1'b1;
    tick();
    rvalid[0] = 1'b0; flush[0] = 1'b0;
    chk("t4 pop in flush no write", we_wb[0], 0);
    chk("t4 pop in flush count", cnt2, 0);

    // 5: spurious response and bus error
    resp(0, 32'h5555_5555, 1'b0);
    chk("t5 spurious set", spur[0], 1);
    chk("t5 spurious no write", we_wb[0], 0);
    enq_op(0, 1'b1, 6'd11);
    resp(0, 32'h6666_6666, 1'b1);
    chk("t5 error no write", we_wb[0], 0);
    chk("t5 error popped", cnt2, 0);
    chk("t5 spurious sticky", spur[0], 1);

    // 6: DEPTH=4 streaming with pointer wrap, then mid-stream reset
    enq_op(1, 1'b1, 6'd1);
    enq_op(1, 1'b1, 6'd2);
    enq_op(1, 1'b1, 6'd3);
    for (int k = 0; k < 10; k++) begin
      ex_valid[1] = 1'b1; we_in[1] = 1'b1; waddr_in[1] = 6'(4 + k);
      rvalid[1] = 1'b1; rdata[1] = 32'h1000 + 32'(k);
      tick();
    end
    ex_valid[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rdata[1] = 32'h2000 + 32'(k);
      tick();
    end
    rvalid[1] = 1'b0;
    tick();
    chk("t6 stream drained", cnt4, 0);
    chk("t6 last write addr", waddr_wb[1], 13);
    for (int k = 0; k < 4; k++) enq_op(1, 1'b1, 6'(20 + k));
    chk("t6 full ready", ex_ready[1], 0);
    chk("t6 full count", cnt4, 4);
    rvalid[1] = 1'b1; rdata[1] = 32'hABC; ex_valid[1] = 1'b1; waddr_in[1] = 6'd30;
    rst = 1'b1;
    tick();
    rst = 1'b0; ex_valid[1] = 1'b0;
    chk("t6 rst we_wb", we_wb[1], 0);
    chk("t6 rst waddr_wb", waddr_wb[1], 0);
    chk("t6 rst wdata_wb", wdata_wb[1], 0);
    chk("t6 rst count", cnt4, 0);
    chk("t6 rst spurious", spur[1], 0);
    chk("t6 rst d0 spurious", spur[0], 0);
    tick();
    rvalid[1] = 1'b0;
    chk("t6 in-flight after rst spurious", spur[1], 1);
    tick();

    chk("d0 scoreboard empty", exp_q0.size(), 0);
    chk("d1 scoreboard empty", exp_q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
